// File: rtl/mdio_peripheral_c22_pkg.sv
// mdio_pkg: shared types and constants for the Clause-22 MDIO peripheral.
package mdio_pkg;
   typedef enum logic [3:0] {
      PREAMBLE, START, OPCODE, PHYAD, REGAD, TA, WDATA, RDATA, SKIP
   } mdio_state_e;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] ST       = 2'b01;
   localparam logic [1:0] TA_WRITE = 2'b10;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int DATA_W  = 16;

   // Preamble counter ceiling and bit times swallowed for a foreign PHY.
   localparam int PRE_SAT   = 32;
   localparam int SKIP_BITS = 18;
endpackage

// File: rtl/mdio_peripheral_c22_if.sv
// Serial MDIO lines plus PHY register-file port, grouped for the peripheral.
interface mdio_peripheral_c22_if;
   import mdio_pkg::*;

   logic               MDIO_OE;
   logic               MDIO_OUT;
   logic               MDIO_IN;
   logic               MDIO_IN_OE;
   logic [DATA_W-1:0]  RD_DATA;
   logic [REGAD_W-1:0] ADDR;
   logic [DATA_W-1:0]  WR_DATA;
   logic               WR_STB;
   logic               RD_STB;
   logic               MDIO_DONE;
   logic               FRAME_ERR;

   // Peripheral side.
   modport slave (
      input  MDIO_OE, MDIO_OUT, RD_DATA,
      output MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB, RD_STB, MDIO_DONE, FRAME_ERR
   );

   // Controller / register-file side.
   modport master (
      output MDIO_OE, MDIO_OUT, RD_DATA,
      input  MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB, RD_STB, MDIO_DONE, FRAME_ERR
   );
endinterface

// File: rtl/mdio_peripheral_c22_shift16.sv
// mdio_shift16: 16-bit shifter, parallel load for read data, serial-in for write data.
module mdio_shift16
   import mdio_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic              ser_i,
   input  logic [DATA_W-1:0] par_i,
   output logic [DATA_W-1:0] q_o
);
   logic [DATA_W-1:0] sh_q, sh_d;

   // Load wins over shift; shifting is MSB first.
   always_comb begin
      sh_d = sh_q;
      if (load_i)       sh_d = par_i;
      else if (shift_i) sh_d = {sh_q[DATA_W-2:0], ser_i};
   end

   // Shift register state.
   always_ff @(posedge clk_i) begin
      if (rst_i) sh_q <= '0;
      else       sh_q <= sh_d;
   end

   assign q_o = sh_q;
endmodule

// File: rtl/mdio_peripheral_c22.sv
// mdio_peripheral_c22: Clause-22 MDIO target. Optional macro MDIO_BROADCAST_EN
// lets write frames addressed to PHYAD 0 hit this PHY as well.
module mdio_peripheral_c22
   import mdio_pkg::*;
#(
   parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd1,
   parameter int                 PREAMBLE_MIN = 32
) (
   input logic                  MDC,
   input logic                  RESET,
   mdio_peripheral_c22_if.slave mdio
);
   mdio_state_e        state_q, state_d;
   logic [5:0]         pre_cnt_q, pre_cnt_d;
   logic [4:0]         bit_cnt_q, bit_cnt_d;
   logic               op_q, op_d;
   logic               rd_q, rd_d;
   logic [PHYAD_W-1:0] phyad_q, phyad_d;
   logic [REGAD_W-1:0] regad_q, regad_d, regad_nx;
   logic [REGAD_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic               wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
   logic               done_q, done_d, ferr_q, ferr_d;
   logic               in_q, in_d, in_oe_q, in_oe_d;
   logic               sh_load, sh_shift, phy_hit, ctrl_bit, bit_i;
   logic [DATA_W-1:0]  sh_q;

   assign bit_i = mdio.MDIO_OUT;

`ifdef MDIO_BROADCAST_EN
   // Broadcast address 0 only ever accepts writes; a read to it must stay silent.
   assign phy_hit = rd_q ? (phyad_q == PHY_ADDR && phyad_q != '0)
                         : (phyad_q == PHY_ADDR || phyad_q == '0);
`else
   assign phy_hit = (phyad_q == PHY_ADDR);
`endif

   // Bits the controller must be driving; losing MDIO_OE here aborts the frame.
   assign ctrl_bit = (state_q inside {START, OPCODE, PHYAD, REGAD, WDATA}) ||
                     (state_q == TA && !rd_q);

   mdio_shift16 u_shift (
      .clk_i   (MDC),
      .rst_i   (RESET),
      .load_i  (sh_load),
      .shift_i (sh_shift),
      .ser_i   (bit_i),
      .par_i   (mdio.RD_DATA),
      .q_o     (sh_q)
   );

   // Frame decoder: next state, counters and registered outputs.
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      bit_cnt_d = bit_cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      phyad_d   = phyad_q;
      regad_d   = regad_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      wr_stb_d  = 1'b0;
      rd_stb_d  = 1'b0;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      in_d      = in_q;
      in_oe_d   = in_oe_q;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      regad_nx  = {regad_q[REGAD_W-2:0], bit_i};

      if (ctrl_bit && !mdio.MDIO_OE) begin
         ferr_d    = 1'b1;
         state_d   = PREAMBLE;
         pre_cnt_d = '0;
      end else begin
         case (state_q)
            PREAMBLE: begin
               if (!mdio.MDIO_OE) pre_cnt_d = '0;
               else if (bit_i) begin
                  if (pre_cnt_q != 6'(PRE_SAT)) pre_cnt_d = pre_cnt_q + 6'd1;
               end else begin
                  // This 0 is the first ST bit only after a long enough run of 1s.
                  if (pre_cnt_q >= 6'(PREAMBLE_MIN)) state_d = START;
                  pre_cnt_d = '0;
               end
            end
            START: begin
               if (bit_i == ST[0]) begin
                  state_d   = OPCODE;
                  bit_cnt_d = '0;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = PREAMBLE;
               end
            end
            OPCODE: begin
               op_d      = bit_i;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd1) begin
                  rd_d      = ({op_q, bit_i} == OP_READ);
                  bit_cnt_d = '0;
                  if ({op_q, bit_i} == OP_READ || {op_q, bit_i} == OP_WRITE) state_d = PHYAD;
                  else begin
                     ferr_d  = 1'b1;
                     state_d = PREAMBLE;
                  end
               end
            end
            PHYAD: begin
               phyad_d   = {phyad_q[PHYAD_W-2:0], bit_i};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(PHYAD_W-1)) begin
                  state_d   = REGAD;
                  bit_cnt_d = '0;
               end
            end
            REGAD: begin
               regad_d   = regad_nx;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(REGAD_W-1)) begin
                  bit_cnt_d = '0;
                  if (!phy_hit) state_d = SKIP;
                  else begin
                     state_d = TA;
                     if (rd_q) begin
                        addr_d   = regad_nx;
                        rd_stb_d = 1'b1;
                     end
                  end
               end
            end
            TA: begin
               if (rd_q) begin
                  // Register file answers one cycle after RD_STB; drive TA bit 2 as 0.
                  sh_load   = 1'b1;
                  in_oe_d   = 1'b1;
                  in_d      = 1'b0;
                  state_d   = RDATA;
                  bit_cnt_d = '0;
               end else if (bit_i != TA_WRITE[~bit_cnt_q[0]]) begin
                  ferr_d    = 1'b1;
                  state_d   = PREAMBLE;
                  pre_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd1) begin
                     state_d   = WDATA;
                     bit_cnt_d = '0;
                  end
               end
            end
            WDATA: begin
               sh_shift  = 1'b1;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(DATA_W-1)) begin
                  wr_data_d = {sh_q[DATA_W-2:0], bit_i};
                  addr_d    = regad_q;
                  wr_stb_d  = 1'b1;
                  done_d    = 1'b1;
                  state_d   = PREAMBLE;
                  pre_cnt_d = '0;
               end
            end
            RDATA: begin
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(DATA_W)) begin
                  in_oe_d   = 1'b0;
                  in_d      = 1'b0;
                  done_d    = 1'b1;
                  state_d   = PREAMBLE;
                  pre_cnt_d = '0;
               end else begin
                  in_d     = sh_q[DATA_W-1];
                  sh_shift = 1'b1;
               end
            end
            SKIP: begin
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(SKIP_BITS-1)) begin
                  state_d   = PREAMBLE;
                  pre_cnt_d = '0;
               end
            end
            default: state_d = PREAMBLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge MDC) begin
      if (RESET) begin
         state_q   <= PREAMBLE;
         pre_cnt_q <= '0;
         bit_cnt_q <= '0;
         op_q      <= 1'b0;
         rd_q      <= 1'b0;
         phyad_q   <= '0;
         regad_q   <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
         wr_stb_q  <= 1'b0;
         rd_stb_q  <= 1'b0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         in_q      <= 1'b0;
         in_oe_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         phyad_q   <= phyad_d;
         regad_q   <= regad_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         wr_stb_q  <= wr_stb_d;
         rd_stb_q  <= rd_stb_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         in_q      <= in_d;
         in_oe_q   <= in_oe_d;
      end
   end

   assign mdio.ADDR       = addr_q;
   assign mdio.WR_DATA    = wr_data_q;
   assign mdio.WR_STB     = wr_stb_q;
   assign mdio.RD_STB     = rd_stb_q;
   assign mdio.MDIO_DONE  = done_q;
   assign mdio.FRAME_ERR  = ferr_q;
   assign mdio.MDIO_IN    = in_q;
   assign mdio.MDIO_IN_OE = in_oe_q;
endmodule

// File: tb/tb_mdio_peripheral_c22.sv
// Bench for mdio_peripheral_c22; expectations follow MDIO_BROADCAST_EN when defined.
module tb_mdio_peripheral_c22;
   localparam logic [4:0] PHY = 5'd1;
`ifdef MDIO_BROADCAST_EN
   localparam bit BCAST = 1'b1;
`else
   localparam bit BCAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mdio_peripheral_c22_if bus();
   logic [15:0] mem [32];
   assign bus.RD_DATA = mem[bus.ADDR];

   mdio_peripheral_c22 #(.PHY_ADDR(PHY), .PREAMBLE_MIN(32)) dut (
      .MDC(clk), .RESET(rst), .mdio(bus.slave)
   );

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, end_cyc = 0;
   int n_wr, n_rd, n_done, n_ferr, n_oe, wr_cyc, rd_cyc, done_cyc, oe_first;
   logic [4:0]  wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic [16:0] rd_bits;
   logic [1:0]  fq[$];

   // Event log sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (bus.WR_STB) begin n_wr++; wr_cyc = cyc; wr_addr = bus.ADDR; wr_data = bus.WR_DATA; end
      if (bus.RD_STB) begin n_rd++; rd_cyc = cyc; rd_addr = bus.ADDR; end
      if (bus.MDIO_DONE) begin n_done++; done_cyc = cyc; end
      if (bus.FRAME_ERR) n_ferr++;
      if (bus.MDIO_IN_OE) begin
         if (n_oe == 0) oe_first = cyc;
         rd_bits = {rd_bits[15:0], bus.MDIO_IN};
         n_oe++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      n_wr = 0; n_rd = 0; n_done = 0; n_ferr = 0; n_oe = 0;
      wr_cyc = -1; rd_cyc = -1; done_cyc = -1; oe_first = -1; rd_bits = '0;
   endtask

   task automatic push(input logic oe, input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) fq.push_back({oe, v[i]});
   endtask

   // Controller view of a frame: bits as driven on MDIO_OE/MDIO_OUT.
   task automatic build(input int pre, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] ra, input logic [15:0] wd, input bit rd);
      fq.delete();
      for (int i = 0; i < pre; i++) fq.push_back(2'b11);
      push(1'b1, 32'h1, 2);
      push(1'b1, {30'd0, op}, 2);
      push(1'b1, {27'd0, phy}, 5);
      push(1'b1, {27'd0, ra}, 5);
      if (rd) push(1'b0, 32'h0, 18);
      else begin
         push(1'b1, 32'h2, 2);
         push(1'b1, {16'd0, wd}, 16);
      end
   endtask

   task automatic play(input int abort_at, input bit do_idle);
      for (int i = 0; i < fq.size(); i++) begin
         @(negedge clk);
         if (abort_at >= 0 && i >= abort_at) begin bus.MDIO_OE = 1'b0; bus.MDIO_OUT = 1'b0; end
         else begin bus.MDIO_OE = fq[i][1]; bus.MDIO_OUT = fq[i][0]; end
      end
      @(posedge clk); #2;
      end_cyc = cyc;
      if (do_idle) begin
         repeat (2) begin @(negedge clk); bus.MDIO_OE = 1'b0; bus.MDIO_OUT = 1'b0; end
         @(posedge clk); #2;
      end
   endtask

   // Reference outcome of one frame derived from the protocol rules alone.
   task automatic frame(input string tag, input int pre, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] ra, input logic [15:0] wd, input int abort_at);
      bit rd, wr, ok_pre, err, hit, do_wr, do_rd;
      rd = (op == 2'b10);
      wr = (op == 2'b01);
      ok_pre = (pre >= 32);
      err = ok_pre && (abort_at >= 0 || !(rd || wr));
      hit = (phy == PHY) || (BCAST && wr && phy == 5'd0);
      do_wr = ok_pre && !err && wr && hit;
      do_rd = ok_pre && !err && rd && hit;
      build(pre, op, phy, ra, wd, rd);
      clr_mon();
      play(abort_at, 1'b1);
      chk({tag, " ferr"}, n_ferr, err ? 1 : 0);
      chk({tag, " wr_stb"}, n_wr, do_wr ? 1 : 0);
      chk({tag, " rd_stb"}, n_rd, do_rd ? 1 : 0);
      chk({tag, " oe_cycles"}, n_oe, do_rd ? 17 : 0);
      chk({tag, " done"}, n_done, (do_wr || do_rd) ? 1 : 0);
      if (do_wr) begin
         chk({tag, " wr_addr"}, wr_addr, ra);
         chk({tag, " wr_data"}, wr_data, wd);
         chk({tag, " wr_time"}, wr_cyc, end_cyc);
         chk({tag, " done_time"}, done_cyc, end_cyc);
         mem[ra] = wd;
      end
      if (do_rd) begin
         chk({tag, " rd_addr"}, rd_addr, ra);
         chk({tag, " rd_bits"}, rd_bits, {1'b0, mem[ra]});
         chk({tag, " oe_time"}, oe_first, rd_cyc + 1);
         chk({tag, " done_time"}, done_cyc, rd_cyc + 18);
         chk({tag, " frame_end"}, done_cyc, end_cyc);
      end
   endtask

   initial begin
      logic [4:0] p;
      int kind;
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      bus.MDIO_OE = 1'b0;
      bus.MDIO_OUT = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("reset outs", {bus.ADDR, bus.WR_DATA, bus.WR_STB, bus.RD_STB, bus.MDIO_DONE,
                         bus.MDIO_IN, bus.MDIO_IN_OE, bus.FRAME_ERR}, 32'h0);
      @(negedge clk); rst = 1'b0;

      frame("write BEEF", 32, 2'b01, PHY, 5'h0A, 16'hBEEF, -1);
      mem[5'h03] = 16'h1234;
      frame("read 1234", 32, 2'b10, PHY, 5'h03, 16'h0, -1);
      frame("mismatch", 32, 2'b01, PHY + 5'd1, 5'h05, 16'h5A5A, -1);
      frame("after mismatch", 32, 2'b01, PHY, 5'h05, 16'($urandom), -1);
      frame("short pre", 31, 2'b01, PHY, 5'h06, 16'h1357, -1);
      frame("bad op", 32, 2'b11, PHY, 5'h06, 16'h0, 32 + 4);
      frame("abort wdata", 32, 2'b01, PHY, 5'h07, 16'hA5A5, 32 + 16 + 8);
      frame("phy0 write", 32, 2'b01, 5'd0, 5'h08, 16'h0F0F, -1);
      frame("phy0 read", 32, 2'b10, 5'd0, 5'h08, 16'h0, -1);
      frame("readback 0A", 33, 2'b10, PHY, 5'h0A, 16'h0, -1);

      for (int n = 0; n < 16; n++) begin
         kind = int'($urandom_range(0, 3));
         p = PHY;
         if (kind == 2) begin
            p = 5'($urandom_range(2, 31));
         end else if (kind == 3) begin
            p = 5'd0;
         end
         frame($sformatf("rand%0d", n), int'($urandom_range(32, 36)),
               ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, p,
               5'($urandom), 16'($urandom), -1);
      end

      // Reset landing at k+5 of a read must drop the bus drive at that edge.
      build(32, 2'b10, PHY, 5'h07, 16'h0, 1'b1);
      while (fq.size() > 32 + 14 + 4) void'(fq.pop_back());
      clr_mon();
      play(-1, 1'b0);
      chk("rst pre oe", bus.MDIO_IN_OE, 1'b1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #2;
      chk("rst oe drop", bus.MDIO_IN_OE, 1'b0);
      chk("rst addr", bus.ADDR, 5'h0);
      chk("rst wr_data", bus.WR_DATA, 16'h0);
      chk("rst pulses", {bus.WR_STB, bus.RD_STB, bus.MDIO_DONE, bus.MDIO_IN, bus.FRAME_ERR}, 5'h0);
      @(negedge clk); rst = 1'b0;
      frame("post reset write", 32, 2'b01, PHY, 5'h1F, 16'hC33C, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
